coin_payout: RTL and testbench
==============================

Name: coin_payout

Overview:
- Change/refund dispenser: the output end of the coin interface that auto_sale accepts on its input side.
- Takes a yuan amount from the sale controller (change on get_ind, refund on cancel) and drives a ten-yuan hopper and a one-yuan hopper with discrete coin pulses.
- Pulses are shaped like the coin_ten/coin_one pulses auto_sale accepts, so outputs can be looped back into auto_sale in simulation.
- Greedy: tens first, then ones; falls back to ones when the ten hopper is empty.

Parameters:
AMT_W, 8, width of pay_amount and remain
PULSE_CYCLES, 2, cycles each coin output is held high (>=1)
GAP_CYCLES, 2, minimum low cycles after each coin pulse (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
pay_req  input  1  level; sampled only in IDLE, starts a payout
pay_amount  input  AMT_W  yuan to pay, captured with pay_req
abort  input  1  terminates payout immediately, clears fault
ten_empty  input  1  ten-yuan hopper empty, sampled in SEL
one_empty  input  1  one-yuan hopper empty, sampled in SEL
coin_ten_out  output  1  ten-yuan eject pulse
coin_one_out  output  1  one-yuan eject pulse
busy  output  1  high in SEL/PULSE/GAP
done  output  1  one-cycle pulse: payout fully complete
fault  output  1  sticky: amount cannot be paid from stock
remain  output  AMT_W  yuan still owed

Behaviour:
- Reset (reset=0, async): state IDLE; remain=0; all outputs 0; timer=0.
- States: IDLE, SEL, PULSE, GAP, DONE, FAULT.
- All outputs are Moore-decoded from registered state/sel/remain. No combinational path from inputs to outputs.
- IDLE, pay_req=1 at edge n:
  - remain<=pay_amount, fault<=0, state<=SEL, so SEL occupies cycle n+1.
- SEL, one cycle, priority order:
  - remain==0 -> DONE.
  - remain>=10 and !ten_empty -> PULSE, sel=TEN.
  - remain>=1 and !one_empty -> PULSE, sel=ONE. This covers remain>=10 with the ten hopper empty.
  - otherwise -> FAULT.
- PULSE:
  - coin_ten_out = (sel==TEN), coin_one_out = (sel==ONE).
  - Lasts exactly PULSE_CYCLES cycles.
  - On the last cycle, remain decrements by 10 or 1. No underflow is possible by construction.
- GAP: both coin outputs 0 for GAP_CYCLES cycles, then SEL.
- Coin k (0-based) output rises at cycle n+2+k*(1+PULSE_CYCLES+GAP_CYCLES).
- For N coins, DONE is at cycle n+2+N*(1+PULSE_CYCLES+GAP_CYCLES).
- DONE: done=1 for exactly one cycle, then IDLE. busy=0.
- FAULT:
  - fault=1, busy=0, remain holds the unpaid amount.
  - Stays in FAULT until abort=1 (-> IDLE, fault cleared) or pay_req=1 (treated as IDLE+pay_req: new amount loaded).
- abort=1, any state except IDLE:
  - Next state IDLE; coin outputs drop next cycle, even mid-pulse.
  - remain keeps its last value for readback. No done pulse.
- abort has priority over pay_req when both are high in FAULT.
- pay_req while busy or in DONE is ignored; no queueing.
- pay_amount==0 -> SEL -> DONE; done at n+2, no coin pulses.
- Hopper flags are only sampled in SEL. A hopper going empty during PULSE/GAP does not affect the current coin.
- coin_ten_out and coin_one_out are never both high.

Decomposition:
- auto_sale_pkg holds:
  - state encoding (3-bit localparams)
  - coin values COIN_TEN=10, COIN_ONE=1
  - sel encoding
- Optional sub-module payout_timer: down-counter loaded with PULSE_CYCLES-1 or GAP_CYCLES-1, with an expiry flag.
- Main FSM and remain datapath stay in coin_payout.

Test Plan:
- Change 13, both hoppers stocked, pay_req at edge n (defaults):
  - coin_ten_out high cycles n+2..n+3.
  - coin_one_out high n+7..n+8, n+12..n+13, n+17..n+18.
  - done at n+22; remain 13->3->2->1->0.
- pay_amount=0 -> no coin pulses, done high at n+2, busy high only at n+1.
- Amount 13, ten_empty=1 -> thirteen coin_one_out pulses, zero ten pulses, done at n+2+13*5=n+67.
- Amount 25, one_empty=1 -> two ten pulses, then FAULT with fault=1, remain=5, busy=0. Then abort=1 -> IDLE, fault=0.
- Amount 20, abort asserted during the first ten pulse (cycle n+3):
  - coin_ten_out low at n+4, state IDLE, remain=20, no done pulse.
  - A pay_req the following cycle is accepted.
- reset driven low mid-GAP -> all outputs 0 and remain=0 immediately (asynchronously). After release, pay_req=1 pays normally; pay_req asserted during busy has no effect.

Source files
------------

// File: rtl/auto_sale_pkg.sv
// ============================================================================
// Module   : auto_sale_pkg
// Purpose  : Shared encodings for the coin payout (state, hopper select, coin values)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package auto_sale_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    localparam logic SEL_ONE = 1'b0;
    localparam logic SEL_TEN = 1'b1;

    localparam int unsigned COIN_TEN = 10;
    localparam int unsigned COIN_ONE = 1;

endpackage

`default_nettype wire

// File: rtl/coin_payout_timer.sv
// ============================================================================
// Module   : payout_timer
// Purpose  : Loadable down-counter timing coin pulse and gap lengths
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module payout_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/coin_payout.sv
// ============================================================================
// Module   : coin_payout
// Purpose  : Greedy change/refund dispenser driving ten- and one-yuan hoppers
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_payout
    import auto_sale_pkg::*;
#(
    parameter int AMT_W        = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pay_req,
    input  logic [AMT_W-1:0] pay_amount,
    input  logic             abort,
    input  logic             ten_empty,
    input  logic             one_empty,
    output logic             coin_ten_out,
    output logic             coin_one_out,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remain
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [AMT_W-1:0] AMT_TEN    = AMT_W'(COIN_TEN);
    localparam logic [AMT_W-1:0] AMT_ONE    = AMT_W'(COIN_ONE);

    logic [2:0]       state_q, state_d;
    logic             sel_q, sel_d;
    logic [AMT_W-1:0] remain_q, remain_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    payout_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        remain_d = remain_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pay_req) begin
                    remain_d = pay_amount;
                    state_d  = ST_SEL;
                end
            end
            ST_SEL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (remain_q == '0) begin
                    state_d = ST_DONE;
                end else if (remain_q >= AMT_TEN && !ten_empty) begin
                    state_d  = ST_PULSE;
                    sel_d    = SEL_TEN;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LOAD;
                end else if (!one_empty) begin
                    // Also reached with remain >= 10 when the ten hopper is empty
                    state_d  = ST_PULSE;
                    sel_d    = SEL_ONE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LOAD;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    remain_d = remain_q - ((sel_q == SEL_TEN) ? AMT_TEN : AMT_ONE);
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    state_d = ST_SEL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                // abort wins over a simultaneous retry request
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pay_req) begin
                    remain_d = pay_amount;
                    state_d  = ST_SEL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_ONE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            remain_q <= remain_d;
        end
    end

    assign coin_ten_out = (state_q == ST_PULSE) && (sel_q == SEL_TEN);
    assign coin_one_out = (state_q == ST_PULSE) && (sel_q == SEL_ONE);
    assign busy         = (state_q == ST_SEL) || (state_q == ST_PULSE) || (state_q == ST_GAP);
    assign done         = (state_q == ST_DONE);
    assign fault        = (state_q == ST_FAULT);
    assign remain       = remain_q;

endmodule

`default_nettype wire

// File: tb/tb_coin_payout.sv
// ============================================================================
// Module   : tb_coin_payout
// Purpose  : Scoreboard bench for coin_payout (greedy model of expected coins)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coin_payout;

    localparam int AMT_W = 8;
    localparam int PC    = 2;
    localparam int GC    = 2;
    localparam int PER   = 1 + PC + GC;

    logic             clk;
    logic             reset;
    logic             pay_req;
    logic [AMT_W-1:0] pay_amount;
    logic             abort;
    logic             ten_empty;
    logic             one_empty;
    logic             coin_ten_out;
    logic             coin_one_out;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remain;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit ten;
        int off;
        int rem;
    } exp_t;

    coin_payout #(
        .AMT_W        (AMT_W),
        .PULSE_CYCLES (PC),
        .GAP_CYCLES   (GC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pay_req      (pay_req),
        .pay_amount   (pay_amount),
        .abort        (abort),
        .ten_empty    (ten_empty),
        .one_empty    (one_empty),
        .coin_ten_out (coin_ten_out),
        .coin_one_out (coin_one_out),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .remain       (remain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Issues pay_req at the next edge (edge n) and scoreboards every coin against a greedy model.
    task automatic run_payout(input int amount, input bit te, input bit oe, input bit spam,
                              input string name);
        exp_t q[$];
        exp_t e;
        int   rem, k, off, end_off, hi_len;
        int   busy_bad, both_bad, width_bad;
        bit   exp_fault, finished, prev;
        rem = amount;
        k = 0;
        exp_fault = 1'b0;
        while (rem != 0 && !exp_fault) begin
            if (rem >= 10 && !te) begin
                q.push_back('{ten: 1'b1, off: 2 + k * PER, rem: rem});
                rem -= 10;
                k++;
            end else if (!oe) begin
                q.push_back('{ten: 1'b0, off: 2 + k * PER, rem: rem});
                rem -= 1;
                k++;
            end else begin
                exp_fault = 1'b1;
            end
        end
        end_off = 2 + k * PER;

        ten_empty  = te;
        one_empty  = oe;
        pay_amount = AMT_W'(amount);
        pay_req    = 1'b1;
        step();
        pay_req = spam;
        if (spam) pay_amount = 8'd99;

        off = 1;
        prev = 1'b0;
        hi_len = 0;
        busy_bad = 0;
        both_bad = 0;
        width_bad = 0;
        finished = 1'b0;
        while (!finished && off <= end_off + 10) begin
            if (coin_ten_out && coin_one_out) both_bad++;
            if (busy !== (off < end_off)) busy_bad++;
            if ((coin_ten_out || coin_one_out) && !prev) begin
                if (q.size() == 0) begin
                    check({name, " unexpected coin at offset"}, off, -1);
                end else begin
                    e = q.pop_front();
                    check({name, " coin type ten"}, int'(coin_ten_out), int'(e.ten));
                    check({name, " coin rise offset"}, off, e.off);
                    check({name, " remain at coin"}, int'(remain), e.rem);
                end
            end
            if (coin_ten_out || coin_one_out) hi_len++;
            if (!(coin_ten_out || coin_one_out) && prev) begin
                if (hi_len != PC) width_bad++;
                hi_len = 0;
            end
            prev = coin_ten_out || coin_one_out;
            if (done || fault) begin
                finished = 1'b1;
                pay_req = 1'b0;
                check({name, " end offset"}, off, end_off);
                check({name, " fault flag"}, int'(fault), int'(exp_fault));
                check({name, " remain at end"}, int'(remain), rem);
            end else begin
                step();
                off++;
            end
        end
        pay_req = 1'b0;
        if (!finished) check({name, " timeout waiting for done/fault"}, off, end_off);
        check({name, " coins outstanding"}, q.size(), 0);
        check({name, " busy pattern errors"}, busy_bad, 0);
        check({name, " both coins high"}, both_bad, 0);
        check({name, " pulse width errors"}, width_bad, 0);
        if (finished && !exp_fault) begin
            step();
            check({name, " done one cycle"}, int'(done), 0);
            step();
            check({name, " idle after done"}, int'(busy), 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        check("reset coin_ten_out", int'(coin_ten_out), 0);
        check("reset coin_one_out", int'(coin_one_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset fault", int'(fault), 0);
        check("reset remain", int'(remain), 0);
        reset = 1'b1;
        step();
    endtask

    task automatic test_change_13();
        run_payout(13, 1'b0, 1'b0, 1'b0, "change13");
    endtask

    task automatic test_zero_amount();
        run_payout(0, 1'b0, 1'b0, 1'b0, "zero");
    endtask

    task automatic test_ten_empty();
        run_payout(13, 1'b1, 1'b0, 1'b0, "ten_empty");
    endtask

    task automatic test_fault_abort();
        run_payout(25, 1'b0, 1'b1, 1'b0, "one_empty");
        check("fault busy low", int'(busy), 0);
        step();
        check("fault sticky", int'(fault), 1);
        abort = 1'b1;
        pay_req = 1'b1;
        pay_amount = 8'd7;
        step();
        abort = 1'b0;
        pay_req = 1'b0;
        check("abort clears fault", int'(fault), 0);
        check("abort beats pay_req", int'(busy), 0);
        check("abort keeps remain", int'(remain), 5);
        one_empty = 1'b0;
        step();
    endtask

    task automatic test_abort_mid_pulse();
        ten_empty  = 1'b0;
        one_empty  = 1'b0;
        pay_amount = 8'd20;
        pay_req    = 1'b1;
        step();
        pay_req = 1'b0;
        step();
        check("abort pre ten pulse n+2", int'(coin_ten_out), 1);
        step();
        check("abort pre ten pulse n+3", int'(coin_ten_out), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort coin drop", int'(coin_ten_out), 0);
        check("abort busy", int'(busy), 0);
        check("abort remain", int'(remain), 20);
        check("abort no done", int'(done), 0);
        run_payout(3, 1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid_gap();
        ten_empty  = 1'b0;
        one_empty  = 1'b0;
        pay_amount = 8'd13;
        pay_req    = 1'b1;
        step();
        pay_req = 1'b0;
        repeat (3) step();
        check("gap coins low", int'(coin_ten_out || coin_one_out), 0);
        check("gap remain", int'(remain), 3);
        #2;
        reset = 1'b0;
        #1;
        check("async reset busy", int'(busy), 0);
        check("async reset remain", int'(remain), 0);
        check("async reset coins", int'(coin_ten_out || coin_one_out), 0);
        #1;
        reset = 1'b1;
        step();
        run_payout(13, 1'b0, 1'b0, 1'b1, "busy_ignore");
    endtask

    initial begin
        reset      = 1'b0;
        pay_req    = 1'b0;
        pay_amount = '0;
        abort      = 1'b0;
        ten_empty  = 1'b0;
        one_empty  = 1'b0;
        test_reset();
        test_change_13();
        test_zero_amount();
        test_ten_empty();
        test_fault_abort();
        test_abort_mid_pulse();
        test_reset_mid_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
